fifo_stream_out: RTL and testbench
==================================

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 Parameter DataWidth, default 32, width of FIFO read data and stream data.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fifo_empty  input  1  empty flag of upstream FIFO.
REQ-005 fifo_rd_data  input  DataWidth  FIFO head data, valid in the same cycle whenever fifo_empty=0.
REQ-006 fifo_rd_en  output  1  pop strobe to the FIFO; a pop occurs when fifo_rd_en=1.
REQ-007 m_valid  output  1  stream data valid.
REQ-008 m_data  output  DataWidth  stream payload.
REQ-009 m_ready  input  1  stream sink ready; transfer ("take") = m_valid & m_ready.
REQ-010 buf_level  output  2  current buffer occupancy, 0..2.

Function
REQ-011 Block SHALL hold a 2-entry output buffer (main, skid) tracked by FSM states EMPTY(0), ONE(1), TWO(2); buf_level SHALL equal the entry count.
REQ-012 fifo_rd_en SHALL equal !rst & !fifo_empty & (state != TWO); it SHALL NOT depend combinationally on m_ready.
REQ-013 fifo_rd_en SHALL never be 1 while fifo_empty=1 or rst=1.
REQ-014 A pop in cycle t SHALL capture fifo_rd_data at the end of t; the word SHALL be visible on m_data no earlier than t+1 (latency from FIFO non-empty to m_valid = 1 cycle when buffer empty).
REQ-015 EMPTY: pop -> ONE (main <= data); else stay.
REQ-016 ONE: pop&take -> ONE (main <= data); pop&!take -> TWO (skid <= data); !pop&take -> EMPTY; else stay.
REQ-017 TWO: take -> ONE (main <= skid); else stay; no pop in TWO.
REQ-018 m_valid SHALL equal (state != EMPTY); m_data SHALL always present main.
REQ-019 While m_valid=1 and m_ready=0, m_data SHALL be stable cycle to cycle.
REQ-020 Words SHALL leave in exact FIFO pop order; no loss, no duplication.
REQ-021 With fifo_empty=0 and m_ready=1 continuously, throughput SHALL be one word per cycle after the first.
REQ-022 m_ready toggling while m_valid=0 SHALL have no effect.

Reset
REQ-023 On rst=1 at posedge: state <= EMPTY, main and skid <= 0, so m_valid=0, m_data=0, buf_level=0 in the following cycle.
REQ-024 rst asserted mid-operation SHALL discard buffered words; popped but untaken words are lost by design (upstream FIFO is reset concurrently).

Configuration
REQ-025 Macro FIFO_STREAM_CNT_EN: when defined, block SHALL add output xfer_cnt (16 bits) counting takes, reset to 0, wrapping 0xFFFF -> 0x0000.
REQ-026 When FIFO_STREAM_CNT_EN is undefined, xfer_cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 FSM state enum (EMPTY/ONE/TWO, 2-bit encoding) and the xfer_cnt width constant SHALL live in shared package fifo_pkg.
REQ-028 No sub-module; the buffer and FSM are a single module.

Verification
REQ-029 Reset: rst=1 for 2 cycles with fifo_empty=0 -> fifo_rd_en=0 throughout; after release m_valid=0, buf_level=0.
REQ-030 Single word: FIFO holds 0xA5A5A5A5, m_ready=1 -> fifo_rd_en=1 cycle 0, m_valid=1 with m_data=0xA5A5A5A5 cycle 1, taken, buf_level returns 0.
REQ-031 Backpressure: FIFO holds 1,2,3, m_ready=0 -> exactly two pops, buf_level=2, fifo_rd_en=0, m_data=1 stable; then m_ready=1 -> output 1,2,3 in order on consecutive cycles.
REQ-032 Streaming: 8 words 0..7, m_ready=1 -> m_valid high 8 consecutive cycles, data 0..7, no bubbles.
REQ-033 Mid-reset: buf_level=2, assert rst -> next cycle m_valid=0, buf_level=0, m_data=0.
REQ-034 Counter (FIFO_STREAM_CNT_EN defined): 65537 takes -> xfer_cnt=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO-to-stream output stage.
// Holds the buffer state encoding and the optional transfer counter width.
package fifo_pkg;

  // Encoding doubles as the buffer occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam int XferCntWidth = 16;

  function automatic logic [1:0] level_of(input state_t st);
    logic [1:0] lvl;
    case (st)
      ST_EMPTY: lvl = 2'd0;
      ST_ONE:   lvl = 2'd1;
      ST_TWO:   lvl = 2'd2;
      default:  lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/fifo_stream_out.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry main/skid buffer.
// Optional take counter output xfer_cnt when FIFO_STREAM_CNT_EN is defined.
module fifo_stream_out
  import fifo_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [DataWidth-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [DataWidth-1:0] m_data,
  input  logic                 m_ready,
  output logic [1:0]           buf_level
`ifdef FIFO_STREAM_CNT_EN
  ,
  output logic [XferCntWidth-1:0] xfer_cnt
`endif
);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [DataWidth-1:0] main_r;
  logic [DataWidth-1:0] skid_r;
  logic [DataWidth-1:0] main_nxt_s;
  logic [DataWidth-1:0] skid_nxt_s;
  logic                 pop_s;
  logic                 take_s;

  // Pop only from what the buffer can absorb regardless of m_ready, so no
  // combinational path exists from the sink back to the FIFO.
  assign pop_s      = !rst && !fifo_empty && (state_r != ST_TWO);
  assign take_s     = m_valid && m_ready;
  assign fifo_rd_en = pop_s;
  assign m_valid    = (state_r != ST_EMPTY);
  assign m_data     = main_r;
  assign buf_level  = level_of(state_r);

  // Next-state and buffer data selection.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (pop_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = fifo_rd_data;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (pop_s && take_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = fifo_rd_data;
        end else if (pop_s) begin
          state_nxt_s = ST_TWO;
          skid_nxt_s  = fifo_rd_data;
        end else if (take_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (take_s) begin
          state_nxt_s = ST_ONE;
          main_nxt_s  = skid_r;
        end else begin
          state_nxt_s = ST_TWO;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        main_nxt_s  = {DataWidth{1'b0}};
        skid_nxt_s  = {DataWidth{1'b0}};
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      main_r  <= {DataWidth{1'b0}};
      skid_r  <= {DataWidth{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      main_r  <= main_nxt_s;
      skid_r  <= skid_nxt_s;
    end
  end

`ifdef FIFO_STREAM_CNT_EN
  logic [XferCntWidth-1:0] xfer_cnt_r;

  // Take counter, wraps naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_r <= {XferCntWidth{1'b0}};
    end else if (take_s) begin
      xfer_cnt_r <= xfer_cnt_r + {{(XferCntWidth-1){1'b0}}, 1'b1};
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Scoreboard bench for fifo_stream_out: an upstream FIFO queue model feeds the DUT,
// pops are pushed to an expected queue and a monitor checks every take in order.
module tb_fifo_stream_out;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_rd_data = 32'd0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready = 1'b0;
  logic [1:0]  buf_level;
`ifdef FIFO_STREAM_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int          total = 0;
  int          bad = 0;
  int          takes_seen = 0;
  logic [15:0] cnt_m = 16'd0;
  logic        after_rst = 1'b1;
  logic [31:0] up_q[$];
  logic [31:0] exp_q[$];

  fifo_stream_out #(.DataWidth(32)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .buf_level(buf_level)
`ifdef FIFO_STREAM_CNT_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every take must deliver the oldest popped word.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        cnt_m = 16'd0;
      end else if (m_valid && m_ready) begin
        takes_seen++;
        cnt_m = cnt_m + 16'd1;
        if (exp_q.size() == 0) begin
          chk("take_without_word", 32'd1, 32'd0);
        end else begin
          chk("take_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  // One cycle: check registered outputs against the model, drive inputs, check the pop strobe.
  task automatic step(input logic rdy, input logic r);
    logic exp_rd;
    @(negedge clk);
    chk("buf_level", {30'd0, buf_level}, exp_q.size());
    chk("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("m_data_head", m_data, exp_q[0]);
    else if (after_rst) chk("m_data_reset", m_data, 32'd0);
`ifdef FIFO_STREAM_CNT_EN
    chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_m});
`endif
    rst = r;
    m_ready = rdy;
    fifo_empty = (up_q.size() == 0);
    fifo_rd_data = (up_q.size() == 0) ? 32'd0 : up_q[0];
    exp_rd = !r && (up_q.size() != 0) && (exp_q.size() < 2);
    #1;
    chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    if (fifo_rd_en && up_q.size() != 0) begin
      exp_q.push_back(up_q.pop_front());
      after_rst = 1'b0;
    end
    if (r) after_rst = 1'b1;
    #1;
  endtask

  initial begin
    int t0;
    int vcnt;
    int rises;
    logic prev_v;
    int guard;

    // Reset held with a non-empty FIFO; no pop may happen.
    up_q.push_back(32'hA5A5A5A5);
    fifo_empty = 1'b0;
    fifo_rd_data = 32'hA5A5A5A5;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Single word, then drain.
    t0 = takes_seen;
    repeat (4) step(1'b1, 1'b0);
    chk("single_takes", takes_seen - t0, 32'd1);

    // Backpressure: exactly two pops, head stable, then three in-order takes.
    up_q.push_back(32'd1);
    up_q.push_back(32'd2);
    up_q.push_back(32'd3);
    repeat (5) step(1'b0, 1'b0);
    chk("bp_level", {30'd0, buf_level}, 32'd2);
    chk("bp_fifo_left", up_q.size(), 32'd1);
    chk("bp_head", m_data, 32'd1);
    t0 = takes_seen;
    repeat (3) step(1'b1, 1'b0);
    chk("bp_burst", takes_seen - t0, 32'd3);
    repeat (2) step(1'b1, 1'b0);

    // Streaming 0..7 without bubbles.
    for (int i = 0; i < 8; i++) up_q.push_back(i);
    vcnt = 0;
    rises = 0;
    prev_v = 1'b0;
    t0 = takes_seen;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (m_valid) vcnt++;
      if (m_valid && !prev_v) rises++;
      prev_v = m_valid;
    end
    chk("stream_valid_cycles", vcnt, 32'd8);
    chk("stream_one_burst", rises, 32'd1);
    chk("stream_takes", takes_seen - t0, 32'd8);

    // Randomized traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      if (up_q.size() < 4 && $urandom_range(0, 1) == 1) up_q.push_back($urandom);
      step(($urandom_range(0, 3) != 0), 1'b0);
    end
    guard = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("drain_done", up_q.size() + exp_q.size(), 32'd0);

    // Mid-operation reset with a full buffer.
    up_q.push_back(32'hDEAD0001);
    up_q.push_back(32'hDEAD0002);
    repeat (3) step(1'b0, 1'b0);
    chk("mid_level_full", {30'd0, buf_level}, 32'd2);
    up_q.delete();
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_level", {30'd0, buf_level}, 32'd0);
    chk("mid_rst_data", m_data, 32'd0);

`ifdef FIFO_STREAM_CNT_EN
    // 65537 takes wrap the counter to 1.
    step(1'b0, 1'b1);
    t0 = takes_seen;
    guard = 0;
    while ((takes_seen - t0) < 65537 && guard < 70000) begin
      if (up_q.size() < 3) up_q.push_back(guard);
      if ((takes_seen - t0) >= 65535) up_q.delete();
      step(((takes_seen - t0) < 65537), 1'b0);
      guard++;
    end
    chk("cnt_takes", takes_seen - t0, 32'd65537);
    step(1'b0, 1'b0);
    chk("cnt_wrap", {16'd0, xfer_cnt}, 32'd1);
`endif

    step(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
